fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage directly upstream of the decode pipeline register. Owns the PC,
//   issues one instruction-memory request at a time, and drives addr/inst/inst_valid straight
//   into decode's addr/inst inputs. Handles pipeline stall, branch flush and variable memory latency.
// PARAMETERS
//   DWIDTH      32   data/address width
//   RESET_ADDR  0    PC value after reset (low 2 bits must be 0)
//   PC_STEP     4    PC increment per accepted instruction
// PORTS
//   clk            in   1       clock, all state updates on rising edge
//   rst            in   1       synchronous reset, active high
//   stall          in   1       hazard unit: hold decode inputs, do not advance
//   flush          in   1       branch taken: discard in-flight work, redirect PC
//   branch_target  in   DWIDTH  redirect address, sampled when flush=1
//   imem_req       out  1       memory request strobe
//   imem_addr      out  DWIDTH  request address (= current PC)
//   imem_ack       in   1       one-cycle pulse: imem_rdata valid
//   imem_rdata     in   DWIDTH  instruction word returned by memory
//   addr           out  DWIDTH  PC of the instruction presented to decode
//   inst           out  DWIDTH  instruction presented to decode (0 = bubble/NOP)
//   inst_valid     out  1       inst/addr hold a real instruction
// BEHAVIOUR
//   Clocking: one clock; reset is synchronous and active-high (clk, rst).
//   Reset: pc=RESET_ADDR, addr=0, inst=0, inst_valid=0, skid empty, state=FETCH; imem_req=0 in the
//     reset cycle, first request (imem_addr=RESET_ADDR) in the cycle after rst drops.
//   States: FETCH (request out), HOLD (word parked in skid, stalled), DROP (flush while request open).
//   Request rule: at most one outstanding request; imem_req and imem_addr stay constant from
//     assertion until the ack cycle. imem_req=1 in FETCH and DROP, 0 in HOLD. Ack may arrive
//     in the same cycle as the request or any later cycle.
//   FETCH, ack, no stall: addr<=pc, inst<=imem_rdata, inst_valid<=1, pc<=pc+PC_STEP; stay FETCH.
//     Back-to-back acks yield one instruction per cycle.
//   FETCH, no ack, no stall: inst<=0, inst_valid<=0 (bubble); addr holds.
//   Any state, stall=1: addr/inst/inst_valid frozen.
//   FETCH, ack, stall: word->skid, skid_addr<=pc, pc<=pc+PC_STEP, go HOLD.
//   HOLD, stall=0: addr<=skid_addr, inst<=skid, inst_valid<=1, skid emptied, go FETCH.
//   flush (highest priority, beats stall in the same cycle): pc<=branch_target with bits[1:0]
//     forced 0; inst<=0, inst_valid<=0; skid emptied.
//     FETCH without ack -> DROP; FETCH with ack same cycle -> word discarded, FETCH at target;
//     HOLD -> FETCH; DROP -> stays DROP with updated pc.
//   DROP: request held at old address; on ack, data discarded, go FETCH; next request uses new pc.
//     stall ignored for state transitions in DROP.
//   Arithmetic: pc+PC_STEP modulo 2^DWIDTH (0xFFFFFFFC+4 -> 0x00000000, no flag).
//   Reset mid-operation wins over everything; an outstanding ack after reset is ignored
//     (memory is reset by the same rst).
// TESTING
//   1 reset 3 cycles, release, imem_ack 1 cycle after each req, data=0x100+pc -> imem_addr 0,4,8;
//     inst 0x100,0x104,0x108 with addr 0,4,8, inst_valid=1.
//   2 ack held high every cycle (zero-wait memory) -> one instruction per cycle, no bubbles.
//   3 ack latency 3 cycles -> imem_addr stable 3 cycles, inst_valid=0 between words, inst=0.
//   4 stall=1 for 4 cycles, ack arrives during stall with 0xDEADBEEF@pc=0x10 -> outputs frozen,
//     imem_req=0 in HOLD; stall drop -> next cycle inst=0xDEADBEEF addr=0x10, then req at 0x14.
//   5 flush with branch_target=0x43 while request to 0x20 is open, ack 2 cycles later ->
//     inst_valid=0, 0x20 data never reaches decode, next imem_addr=0x40.
//   6 flush and stall same cycle; and RESET_ADDR=0xFFFFFFFC -> flush wins; next pc wraps to 0x0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one instruction-memory
// request outstanding, and presents addr/inst/inst_valid to the decode register.
// A one-entry skid buffer parks a word that returns while decode is stalled;
// a DROP state swallows the reply to a request that a branch flush made stale.
module fetch_stage #(
    parameter int                 DWIDTH     = 32,
    parameter logic [DWIDTH-1:0]  RESET_ADDR = {DWIDTH{1'b0}},
    parameter int                 PC_STEP    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [DWIDTH-1:0] branch_target,
    output logic              imem_req,
    output logic [DWIDTH-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DWIDTH-1:0] imem_rdata,
    output logic [DWIDTH-1:0] addr,
    output logic [DWIDTH-1:0] inst,
    output logic              inst_valid
);

    localparam logic [DWIDTH-1:0] STEP_V = DWIDTH'(PC_STEP);
    localparam logic [DWIDTH-1:0] ZERO_V = {DWIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] inst_q, inst_d;
    logic              inst_valid_q, inst_valid_d;
    logic [DWIDTH-1:0] skid_q, skid_d;
    logic [DWIDTH-1:0] skid_addr_q, skid_addr_d;
    logic              req_q, req_d;
    logic [DWIDTH-1:0] req_addr_q, req_addr_d;

    logic              ack_s;
    logic [DWIDTH-1:0] pc_inc_s;
    logic [DWIDTH-1:0] target_s;

    // An ack only counts while our request is actually on the bus; this also
    // discards a stray ack in the first cycle after reset.
    assign ack_s    = imem_ack & req_q;
    assign pc_inc_s = pc_q + STEP_V;
    assign target_s = {branch_target[DWIDTH-1:2], 2'b00};

    // Next-state logic: normal fetch/stall handling first, then flush overrides it.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        skid_d       = skid_q;
        skid_addr_d  = skid_addr_q;

        case (state_q)
            ST_FETCH: begin
                if (ack_s) begin
                    pc_d = pc_inc_s;
                    if (stall) begin
                        skid_d      = imem_rdata;
                        skid_addr_d = pc_q;
                        state_d     = ST_HOLD;
                    end else begin
                        addr_d       = pc_q;
                        inst_d       = imem_rdata;
                        inst_valid_d = 1'b1;
                    end
                end else if (!stall) begin
                    inst_d       = ZERO_V;
                    inst_valid_d = 1'b0;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    addr_d       = skid_addr_q;
                    inst_d       = skid_q;
                    inst_valid_d = 1'b1;
                    skid_d       = ZERO_V;
                    state_d      = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_DROP: begin
                // Stale reply is thrown away; stall has no say over this transition.
                if (ack_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (flush) begin
            pc_d         = target_s;
            addr_d       = addr_q;
            inst_d       = ZERO_V;
            inst_valid_d = 1'b0;
            skid_d       = ZERO_V;
            case (state_q)
                ST_FETCH: state_d = (req_q && !ack_s) ? ST_DROP : ST_FETCH;
                ST_HOLD:  state_d = ST_FETCH;
                ST_DROP:  state_d = ack_s ? ST_FETCH : ST_DROP;
                default:  state_d = ST_FETCH;
            endcase
        end else begin
            skid_addr_d = skid_addr_d;
        end
    end

    // Request strobe/address for the next cycle: idle only while a word is parked,
    // and an open request keeps its original address while we wait to drop it.
    always_comb begin
        req_d = (state_d != ST_HOLD);
        if (state_d == ST_DROP) begin
            req_addr_d = req_addr_q;
        end else begin
            req_addr_d = pc_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_ADDR;
            addr_q       <= ZERO_V;
            inst_q       <= ZERO_V;
            inst_valid_q <= 1'b0;
            skid_q       <= ZERO_V;
            skid_addr_q  <= ZERO_V;
            req_q        <= 1'b0;
            req_addr_q   <= RESET_ADDR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            skid_q       <= skid_d;
            skid_addr_q  <= skid_addr_d;
            req_q        <= req_d;
            req_addr_q   <= req_addr_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = req_addr_q;
    assign addr       = addr_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;

endmodule
